// File: rtl/aemb_dwb_slave.sv
// aeMB data-bus Wishbone slave RAM: falling-edge, byte lanes, WAIT wait states.
// Define AEMB_DWB_ERR_EN to error out requests with upper address bits set.
module aemb_dwb_slave #(
  parameter int AW   = 10,
  parameter int WAIT = 1
) (
  input  logic        nclk,
  input  logic        frst,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK
  } state_t;

  state_t state, state_nx;
  logic [2:0] cnt, cnt_nx;

  logic [AW-1:0] idx_q, idx;
  logic [31:0]   dat_q, dat;
  logic [3:0]    sel_q, sel;
  logic          we_q, we;
  logic          bad_q, bad;
  logic          bad_in;
  logic          go;
  logic          wr;

  logic [31:0] mem [2**AW];

`ifdef AEMB_DWB_ERR_EN
  assign bad_in = |wb_adr_i[31:AW+2];
  logic unused_adr;
  assign unused_adr = ^wb_adr_i[1:0];
`else
  assign bad_in = 1'b0;
  logic unused_adr;
  assign unused_adr = ^{wb_adr_i[31:AW+2], wb_adr_i[1:0]};
`endif

  // In IDLE the request is taken straight from the bus so WAIT=0 can commit.
  always_comb begin
    idx = idx_q;
    dat = dat_q;
    sel = sel_q;
    we  = we_q;
    bad = bad_q;
    if (state == S_IDLE) begin
      idx = wb_adr_i[AW+1:2];
      dat = wb_dat_i;
      sel = wb_sel_i;
      we  = wb_we_i;
      bad = bad_in;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      S_IDLE: begin
        if (wb_stb_i) begin
          cnt_nx   = 3'(WAIT);
          state_nx = (WAIT == 0) ? S_ACK : S_WAIT;
        end
      end
      S_WAIT: begin
        if (!wb_stb_i) begin
          cnt_nx   = '0;
          state_nx = S_IDLE;
        end else begin
          cnt_nx = cnt - 3'd1;
          if (cnt == 3'd1) state_nx = S_ACK;
        end
      end
      S_ACK: begin
        cnt_nx   = '0;
        state_nx = S_IDLE;
      end
      default: begin
        cnt_nx   = '0;
        state_nx = S_IDLE;
      end
    endcase
  end

  assign go = (state_nx == S_ACK);
  assign wr = frst && go && we && !bad;

  always_ff @(negedge nclk or negedge frst) begin
    if (!frst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= '0;
      idx_q    <= '0;
      dat_q    <= '0;
      sel_q    <= '0;
      we_q     <= 1'b0;
      bad_q    <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      wb_ack_o <= go && !bad;
      wb_err_o <= go && bad;
      if (state == S_IDLE && wb_stb_i) begin
        idx_q <= wb_adr_i[AW+1:2];
        dat_q <= wb_dat_i;
        sel_q <= wb_sel_i;
        we_q  <= wb_we_i;
        bad_q <= bad_in;
      end
      if (go && !we && !bad) wb_dat_o <= mem[idx];
    end
  end

  always_ff @(negedge nclk) begin
    if (wr) begin
      for (int b = 0; b < 4; b++) begin
        if (sel[b]) mem[idx][b*8 +: 8] <= dat[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_aemb_dwb_slave.sv
// Randomized bench for aemb_dwb_slave: three instances (WAIT=1,0,3)
// checked against a transaction-level memory and timing model.
module tb_aemb_dwb_slave;

  logic        nclk;
  logic        frst;
  logic [31:0] adr  [3];
  logic [31:0] dat  [3];
  logic [3:0]  sel  [3];
  logic        stb  [3];
  logic        we   [3];
  logic [31:0] dout [3];
  logic        ack  [3];
  logic        err  [3];

  int n_chk;
  int n_err;

  logic [31:0] mem_m    [3][16];
  logic [31:0] exp_dout [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    aemb_dwb_slave #(
      .AW  (10),
      .WAIT(g == 0 ? 1 : (g == 1 ? 0 : 3))
    ) u_dut (
      .nclk    (nclk),
      .frst    (frst),
      .wb_adr_i(adr[g]),
      .wb_dat_i(dat[g]),
      .wb_sel_i(sel[g]),
      .wb_stb_i(stb[g]),
      .wb_we_i (we[g]),
      .wb_dat_o(dout[g]),
      .wb_ack_o(ack[g]),
      .wb_err_o(err[g])
    );
  end

  initial nclk = 1'b1;
  always #5 nclk = ~nclk;

  function automatic int wt(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic is_bad(input logic [31:0] a);
`ifdef AEMB_DWB_ERR_EN
    return |a[31:12];
`else
    return 1'b0;
`endif
  endfunction

  // ab = 0: run to completion; ab = j: drop stb after j falling edges.
  task automatic xfer(input int k, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s,
                      input int ab, output logic [31:0] rd);
    int lat, got, na, ne;
    logic bad;
    logic [3:0] ix;
    adr[k] = a;
    dat[k] = d;
    sel[k] = s;
    we[k]  = w;
    stb[k] = 1'b1;
    lat = wt(k) + 1;
    got = 0;
    na  = 0;
    ne  = 0;
    for (int i = 1; i <= lat + 2; i++) begin
      @(posedge nclk);
      chk("excl", {31'b0, ack[k] & err[k]}, 32'd0);
      if (ack[k]) na++;
      if (err[k]) ne++;
      if ((ack[k] || err[k]) && got == 0) got = i;
      if (ack[k] || err[k] || i == ab) stb[k] = 1'b0;
    end
    stb[k] = 1'b0;
    ix  = a[5:2];
    bad = is_bad(a);
    if (ab != 0) begin
      chk("abort_ack", na, 0);
      chk("abort_err", ne, 0);
    end else begin
      chk("latency", got, lat);
      chk("n_ack", na, bad ? 0 : 1);
      chk("n_err", ne, bad ? 1 : 0);
      if (!bad) begin
        if (w) begin
          for (int b = 0; b < 4; b++)
            if (s[b]) mem_m[k][ix][b*8 +: 8] = d[b*8 +: 8];
        end else begin
          exp_dout[k] = mem_m[k][ix];
        end
      end
    end
    rd = dout[k];
    chk("dout", rd, exp_dout[k]);
  endtask

  initial begin
    logic [31:0] rd, a;
    int ab;
    n_chk = 0;
    n_err = 0;
    frst  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      adr[k] = '0; dat[k] = '0; sel[k] = '0;
      stb[k] = 1'b0; we[k] = 1'b0; exp_dout[k] = '0;
    end
    repeat (3) @(posedge nclk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_ack", {31'b0, ack[k]}, 0);
      chk("rst_err", {31'b0, err[k]}, 0);
      chk("rst_dout", dout[k], 0);
    end
    frst = 1'b1;
    @(posedge nclk);

    xfer(0, 1'b0, 32'h0, 32'h0, 4'hF, 0, rd);
    for (int k = 0; k < 3; k++)
      for (int w = 0; w < 16; w++) begin
        mem_m[k][w] = 'x;
        xfer(k, 1'b1, 32'(w * 4), 32'h0, 4'hF, 0, rd);
      end

    xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd);
    xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, rd);
    chk("rd_full", rd, 32'hDEADBEEF);
    xfer(0, 1'b1, 32'h10, 32'h11000000, 4'b1000, 0, rd);
    xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, 0, rd);
    chk("rd_part", rd, 32'h11ADBEEF);
    xfer(0, 1'b1, 32'h0, 32'h0, 4'h0, 0, rd);

    xfer(1, 1'b1, 32'h0, 32'hA0A0A0A0, 4'hF, 0, rd);
    xfer(1, 1'b1, 32'h4, 32'hB1B1B1B1, 4'hF, 0, rd);
    xfer(1, 1'b1, 32'h8, 32'hC2C2C2C2, 4'hF, 0, rd);
    adr[1] = 32'h0;
    we[1]  = 1'b0;
    sel[1] = 4'hF;
    stb[1] = 1'b1;
    for (int j = 0; j < 7; j++) begin
      @(posedge nclk);
      chk("b2b_ack", {31'b0, ack[1]}, (j % 2 == 0 && j < 6) ? 1 : 0);
      if (ack[1]) begin
        exp_dout[1] = mem_m[1][j / 2];
        chk("b2b_dat", dout[1], exp_dout[1]);
        adr[1] = 32'((j / 2 + 1) * 4);
        if (j == 4) stb[1] = 1'b0;
      end
    end
    stb[1] = 1'b0;

    xfer(2, 1'b1, 32'h14, 32'h12345678, 4'hF, 1, rd);
    xfer(2, 1'b0, 32'h14, 32'h0, 4'hF, 0, rd);

    xfer(0, 1'b1, 32'h00001000, 32'hCAFEF00D, 4'hF, 0, rd);
    xfer(0, 1'b0, 32'h0, 32'h0, 4'hF, 0, rd);

    adr[1] = 32'h8; we[1] = 1'b0; stb[1] = 1'b1;
    @(posedge nclk);
    chk("pre_rst_ack", {31'b0, ack[1]}, 1);
    frst = 1'b0;
    #1;
    chk("async_ack", {31'b0, ack[1]}, 0);
    chk("async_dout", dout[1], 0);
    stb[1] = 1'b0;
    @(posedge nclk);
    frst = 1'b1;
    for (int k = 0; k < 3; k++) exp_dout[k] = '0;

    adr[2] = 32'h20; dat[2] = $urandom; sel[2] = 4'hF;
    we[2] = 1'b1; stb[2] = 1'b1;
    repeat (2) @(posedge nclk);
    frst = 1'b0;
    #1;
    chk("mid_rst_ack", {31'b0, ack[2]}, 0);
    chk("mid_rst_err", {31'b0, err[2]}, 0);
    stb[2] = 1'b0;
    repeat (2) @(posedge nclk);
    chk("mid_rst_dout", dout[2], 0);
    frst = 1'b1;
    repeat (4) begin
      @(posedge nclk);
      chk("mid_rst_noack", {31'b0, ack[2]}, 0);
    end
    xfer(2, 1'b0, 32'h20, 32'h0, 4'hF, 0, rd);
    chk("mid_rst_mem", rd, 32'h0);

    for (int n = 0; n < 450; n++) begin
      int k;
      k = n % 3;
      a = 32'($urandom_range(15) * 4) | 32'($urandom_range(3));
      if ($urandom_range(7) == 0) a = a | 32'($urandom_range(255, 1) << 12);
      ab = 0;
      if (wt(k) > 0 && $urandom_range(7) == 0) ab = $urandom_range(wt(k), 1);
      xfer(k, 1'($urandom_range(1)), a, $urandom,
           4'($urandom_range(15)), ab, rd);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
